// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier with early termination and per-transaction
// signed/unsigned mode; magnitudes are multiplied and the sign is applied in NORM.
module seq_mult_param #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [CW-1:0]        iters
);

  typedef enum logic [1:0] {IDLE, RUN, NORM, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   acc_a;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   m;
  logic               c;
  logic [CW-1:0]      k;
  logic               neg;

  logic [WIDTH-1:0]   a_in_mag;
  logic [WIDTH-1:0]   b_in_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH-1:0]   m_nxt;
  logic [CW-1:0]      k_nxt;
  logic               last_iter;
  logic [CW-1:0]      shamt;
  logic [2*WIDTH-1:0] mag;

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic sm);
    return (sm && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  assign a_in_mag  = magnitude(multiplicand, signed_mode);
  assign b_in_mag  = magnitude(multiplier, signed_mode);
  assign sum       = {c, acc_a} + {1'b0, (q[0] ? b_mag : '0)};
  assign shifted   = {sum, q} >> 1;
  assign m_nxt     = m >> 1;
  assign k_nxt     = k + 1'b1;
  assign last_iter = (m_nxt == '0) || (k_nxt == CW'(WIDTH));
  // After k iterations the product sits left-aligned by WIDTH-k in {A,Q}.
  assign shamt     = CW'(WIDTH) - k;
  assign mag       = (k == '0) ? '0 : ({acc_a, q} >> shamt);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)
              state_nxt = ((a_in_mag == '0) || (b_in_mag == '0)) ? NORM : RUN;
      RUN:  if (last_iter) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_a   <= '0;
      q       <= '0;
      b_mag   <= '0;
      m       <= '0;
      c       <= 1'b0;
      k       <= '0;
      neg     <= 1'b0;
      product <= '0;
      iters   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          b_mag <= a_in_mag;
          q     <= b_in_mag;
          m     <= b_in_mag;
          neg   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          acc_a <= '0;
          c     <= 1'b0;
          k     <= '0;
        end
        RUN: begin
          c     <= shifted[2*WIDTH];
          acc_a <= shifted[2*WIDTH-1:WIDTH];
          q     <= shifted[WIDTH-1:0];
          m     <= m_nxt;
          k     <= k_nxt;
        end
        NORM: begin
          product <= neg ? -mag : mag;
          iters   <= k;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: arithmetic model of product/iters/latency
// plus literal expectations for each vector.
module tb_seq_mult_param;
  localparam int W  = 8;
  localparam int CB = $clog2(W + 1);

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           signed_mode;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic [CB-1:0]  iters;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] m_prod;
  logic [CB-1:0]  m_iters;
  int             m_lat;

  seq_mult_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .multiplicand(multiplicand),
    .multiplier(multiplier), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .iters(iters)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain integer multiply; iteration count is the bit length of |b|.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm);
    int ia, ib, p, mb;
    ia = sm ? int'($signed(a)) : int'(a);
    ib = sm ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    mb = (ib < 0) ? -ib : ib;
    m_prod  = p[2*W-1:0];
    m_iters = (ia == 0 || ib == 0) ? '0 : CB'($clog2(mb + 1));
    m_lat   = int'(m_iters) + 1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("model_product", 32'(product), 32'(m_prod));
      chk("model_iters", 32'(iters), 32'(m_iters));
      chk("in_ready_in_done", 32'(in_ready), 0);
    end
  end

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic [2*W-1:0] exp_p,
                         input int exp_i, input int exp_lat);
    int n;
    @(negedge clk);
    multiplicand = a; multiplier = b; signed_mode = sm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(in_ready), 1);
    @(posedge clk);
    model(a, b, sm);
    #1;
    in_valid = 1'b0; multiplicand = ~a; multiplier = 8'hA5; signed_mode = ~sm;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("model_latency", 32'(n), 32'(m_lat));
    chk("lit_product", 32'(product), 32'(exp_p));
    chk("lit_iters", 32'(iters), 32'(exp_i));
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_out_valid", 32'(out_valid), 0);
    chk("hs_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; signed_mode = 1'b0;
    multiplicand = '0; multiplier = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_product", 32'(product), 0);
    chk("rst_iters", 32'(iters), 0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(8'd13, 8'd11, 1'b0, 16'd143, 4, 5);     handshake();
    run_txn(8'd0, 8'd200, 1'b0, 16'd0, 0, 1);       handshake();
    run_txn(8'd77, 8'd0, 1'b0, 16'd0, 0, 1);        handshake();
    run_txn(8'd255, 8'd255, 1'b0, 16'hFE01, 8, 9);  handshake();
    run_txn(8'hFD, 8'd5, 1'b1, 16'hFFF1, 3, 4);     handshake();
    run_txn(8'd5, 8'hFD, 1'b1, 16'hFFF1, 2, 3);     handshake();
    run_txn(8'h80, 8'h80, 1'b1, 16'h4000, 8, 9);    handshake();
    run_txn(8'h80, 8'h80, 1'b0, 16'h4000, 8, 9);    handshake();

    // Backpressure: output held while new operands are offered and refused.
    run_txn(8'hF9, 8'd6, 1'b1, 16'hFFD6, 3, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      multiplicand = W'($urandom_range(1, 255));
      multiplier = W'($urandom_range(1, 255));
      signed_mode = i[1];
      #1;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_product", 32'(product), 32'h0000FFD6);
      chk("bp_iters", 32'(iters), 3);
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_no_capture_product", 32'(product), 32'h0000FFD6);
    chk("bp_no_capture_iters", 32'(iters), 3);

    // Reset during the 4th RUN cycle.
    @(negedge clk);
    multiplicand = 8'd255; multiplier = 8'd255; signed_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_product", 32'(product), 0);
    chk("midrst_iters", 32'(iters), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    run_txn(8'd6, 8'd7, 1'b0, 16'd42, 3, 4);        handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised sequential shift-add multiplier with early termination. It accepts one operand pair per transaction through a valid/ready handshake and supports signed (two's complement) and unsigned modes per transaction. It stops iterating as soon as the remaining multiplier bits are zero, then normalises and holds the product until the consumer accepts it. It serves as the general-purpose multiply engine for datapaths that cannot afford a combinational array multiplier.

## Interface
- WIDTH, 8: operand width in bits; legal range is WIDTH >= 2.
- CW, $clog2(WIDTH+1): width of the iteration counter (derived; do not override).

Ports (one clock domain: `clk`; reset is asynchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands; high exactly when in IDLE.
- signed_mode  in  1  1 = operands are two's complement; sampled with the operands.
- multiplicand  in  WIDTH  operand a.
- multiplier  in  WIDTH  operand b; its magnitude sets the iteration count.
- out_valid  out  1  product valid; held until accepted.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  result; signed or unsigned per the captured mode.
- iters  out  CW  number of add/shift iterations used for this product.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: one add-and-shift iteration per cycle.
  - NORM: result formation.
  - DONE: out_valid=1.
- Accept (IDLE, in_valid=1): capture values as follows.
  - Magnitudes are |a| → B, |b| → Q and M. Negation applies only when signed_mode=1 and the sign bit is set. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned in WIDTH bits.
  - Sign flag: neg = signed_mode & (a[W−1] ^ b[W−1]).
  - Clear A, C and the counter k.
  - If B==0 or M==0, go to NORM; otherwise go to RUN.
- RUN iteration:
  - {C,A} = A + (Q[0] ? B : 0), then {C,A,Q} ← {C,A,Q} >> 1.
  - M ← M >> 1 and k ← k+1.
  - The add and the shift happen in the same cycle.
- RUN exit: go to NORM when the post-shift M is 0, or when k reaches WIDTH. Otherwise stay in RUN.
- k = index of the highest set bit of |b| plus 1, with 1 ≤ k ≤ WIDTH. For zero operands, k = 0.
- NORM:
  - mag = {A,Q} >> (WIDTH − k); mag is forced to 0 when k = 0.
  - product ← neg ? −mag : mag, and iters ← k.
  - Go to DONE.
- DONE: out_valid=1. When out_ready=1, go to IDLE.
  - in_ready stays 0 during DONE. Operands cannot be accepted in the same cycle as the output handshake.
- product and iters keep their last value after the handshake, until the next NORM.
- Signed extremes are exact: the 2*WIDTH-bit result always holds the full product, including (−2^(W−1))².
- No overflow or truncation occurs in any mode.

## Timing
- Reset values (rst high, asynchronous): state=IDLE, in_ready=1, out_valid=0, product=0, iters=0. All internal registers are 0.
- Reset mid-operation (RUN, NORM or DONE) aborts the transaction with no output. The block returns to IDLE.
- Latency: the accept edge is E0. out_valid is high after edge E(k+1): k RUN cycles plus 1 NORM cycle.
  - Zero operand: latency 1 cycle.
  - Worst case: WIDTH+1 cycles.
- Throughput: one transaction per k+3 cycles minimum, counting accept, k RUN cycles, NORM and a DONE handshake in the first cycle.
- in_valid and the operands are ignored whenever in_ready=0.
- out_valid, product and iters are registered and stable while out_valid=1 and out_ready=0.
- signed_mode changes after acceptance do not affect the transaction in flight.

## Test plan
1. **Unsigned basic:** WIDTH=8, unsigned, a=13, b=11 → product=143, iters=4, out_valid 5 cycles after accept.
2. **Zero skip:**
   - a=0, b=200 → product=0, iters=0, latency 1.
   - a=77, b=0 → same result.
3. **Full length:** unsigned, a=255, b=255 → product=0xFE01, iters=8, latency 9.
4. **Signed:**
   - a=−3, b=5 → product=0xFFF1 (−15), iters=3, latency 4.
   - a=−128, b=−128 → product=0x4000, iters=8.
   - Unsigned a=0x80, b=0x80 → also 0x4000.
5. **Backpressure:** hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands.
   - out_valid, product and iters stay stable.
   - in_ready=0 throughout and no capture occurs.
   - Raise out_ready: the next cycle is IDLE with in_ready=1.
6. **Reset mid-RUN:** start a=255, b=255 and assert rst for 1 cycle at the 4th RUN cycle.
   - Immediately out_valid=0, product=0, in_ready=1.
   - A following a=6, b=7 → 42, iters=3.
